calc_seq: RTL and testbench
===========================

CALC_SEQ -- requirements
Module: calc_seq

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles from alu_start to alu_done before an error is declared (legal range 1..255).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops rise on its positive edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_number, input, 4 bits: operand value from the switches.
REQ-005 The block SHALL have port key, input, 2 bits: raw asynchronous buttons, active-high; key[0]=ENTER, key[1]=CLEAR.
REQ-006 The block SHALL have port op_sel, input, 2 bits: operator code from the switches (0 add, 1 sub, 2 mul, 3 div).
REQ-007 The block SHALL have port alu_done, input, 1 bit: single-cycle ALU completion strobe.
REQ-008 The block SHALL have port alu_err, input, 1 bit: ALU error flag, valid only with alu_done.
REQ-009 The block SHALL have port alu_result, input, 8 bits: ALU result, valid only with alu_done.
REQ-010 The block SHALL have port reg_1, output, 4 bits: latched operand A.
REQ-011 The block SHALL have port reg_2, output, 4 bits: latched operand B.
REQ-012 The block SHALL have port op, output, 2 bits: latched operator.
REQ-013 The block SHALL have port alu_start, output, 1 bit: one-cycle ALU start pulse.
REQ-014 The block SHALL have port ind, output, 8 bits: indicator/display value.
REQ-015 The block SHALL have port err, output, 1 bit: error indicator.

Function
REQ-016 Each key bit SHALL pass through a 2-flop synchronizer; an event SHALL be a 0->1 transition of the synchronized bit, producing a one-cycle internal pulse 3 cycles after the raw edge at the latest.
REQ-017 The FSM states SHALL be GET_A, GET_B, GET_OP, EXEC, SHOW, ERROR.
REQ-018 In GET_A, ind SHALL track {4'h0, in_number} continuously; an ENTER event SHALL latch reg_1=in_number and move to GET_B.
REQ-019 In GET_B, ind SHALL track {4'h0, in_number}; an ENTER event SHALL latch reg_2=in_number and move to GET_OP.
REQ-020 In GET_OP, ind SHALL show {6'h0, op_sel}; an ENTER event SHALL latch op=op_sel, pulse alu_start for exactly one cycle, and move to EXEC.
REQ-021 In EXEC, an 8-bit cycle counter SHALL start at 0 on the cycle after alu_start and increment each cycle; alu_done with alu_err=0 SHALL load ind=alu_result and move to SHOW; alu_done with alu_err=1 SHALL move to ERROR.
REQ-022 In EXEC, if the counter reaches TIMEOUT without alu_done, the FSM SHALL move to ERROR; alu_done arriving in that same cycle SHALL take precedence.
REQ-023 In EXEC, ENTER events SHALL be ignored and ind SHALL hold its previous value.
REQ-024 In SHOW, ind SHALL hold the result; an ENTER event SHALL move to GET_A with reg_1, reg_2 and op retained until overwritten.
REQ-025 In ERROR, err SHALL be 1 and ind SHALL be 8'hEE; only CLEAR leaves it.
REQ-026 A CLEAR event in any state SHALL clear reg_1, reg_2, op, ind, err, the counter and alu_start, and move to GET_A the next cycle; CLEAR and ENTER in the same cycle SHALL act as CLEAR only.
REQ-027 alu_done received outside EXEC SHALL be ignored.
REQ-028 err SHALL be 0 in every state except ERROR.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state=GET_A, reg_1=0, reg_2=0, op=0, alu_start=0, ind=0, err=0, counter=0, and all synchronizer flops to 0.
REQ-030 Reset deasserted mid-EXEC SHALL abandon the operation; a later alu_done SHALL be ignored.
REQ-031 A key held high through reset release SHALL NOT produce an event until it is released and pressed again.

Verification
REQ-032 ENTER with in_number=3, ENTER with 5, ENTER with op_sel=0; ALU returns done, result=8 after 4 cycles -> reg_1=3, reg_2=5, op=0, single alu_start pulse, ind=8'h08, err=0.
REQ-033 Full sequence with op_sel=3; ALU returns done, err=1 -> ind=8'hEE, err=1; CLEAR -> GET_A, all outputs 0.
REQ-034 Reach EXEC with TIMEOUT=15 and no alu_done -> ERROR exactly 15 cycles after the cycle following alu_start; alu_done exactly at the 15th cycle -> SHOW instead.
REQ-035 CLEAR and ENTER rising together in GET_B -> GET_A, reg_1=0, reg_2 unchanged at 0.
REQ-036 rst_n pulsed low in EXEC, then alu_done -> outputs stay at reset values, state GET_A.
REQ-037 ENTER held high for 100 cycles in GET_A -> exactly one transition to GET_B; pulses during EXEC -> no state change.

Source files
------------

// File: rtl/calc_seq.sv
// calc_seq: four-function calculator sequencer.
// Collects operand A, operand B and an operator from switches using the ENTER
// key. It then launches an external ALU and shows the result, or shows an error
// on ALU failure or timeout. CLEAR returns to operand entry from any state.
module calc_seq #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_number,
    input  logic [1:0] key,
    input  logic [1:0] op_sel,
    input  logic       alu_done,
    input  logic       alu_err,
    input  logic [7:0] alu_result,
    output logic [3:0] reg_1,
    output logic [3:0] reg_2,
    output logic [1:0] op,
    output logic       alu_start,
    output logic [7:0] ind,
    output logic       err
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Last count value at which EXEC may still wait; the next step would reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    // vld_q[1] is set once the synchronizers hold real key samples rather than reset zeros.
    logic [1:0] vld_q;
    logic [1:0] key_ev;

    // Track how many cycles have elapsed since reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    // Each key is synchronized and then rising-edge detected.
    // A key must be seen low after reset before it is armed. This means a key held
    // through reset release must be released and pressed again to count.
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic meta_q;
        logic sync_q;
        logic prev_q;
        logic armed_q;

        // Synchronize the key, keep the previous sample, and arm on the first valid low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q  <= 1'b0;
                sync_q  <= 1'b0;
                prev_q  <= 1'b0;
                armed_q <= 1'b0;
            end else begin
                meta_q  <= key[gi];
                sync_q  <= meta_q;
                prev_q  <= sync_q;
                armed_q <= armed_q | (vld_q[1] & ~sync_q);
            end
        end

        assign key_ev[gi] = sync_q & ~prev_q & armed_q;
    end

    logic enter_ev;
    logic clear_ev;
    assign enter_ev = key_ev[0];
    assign clear_ev = key_ev[1];

    state_t     state_q, state_d;
    logic [3:0] reg1_q, reg1_d;
    logic [3:0] reg2_q, reg2_d;
    logic [1:0] op_q, op_d;
    logic       start_q, start_d;
    logic [7:0] ind_q, ind_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GET_A;
            reg1_q  <= 4'h0;
            reg2_q  <= 4'h0;
            op_q    <= 2'd0;
            start_q <= 1'b0;
            ind_q   <= 8'h00;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            op_q    <= op_d;
            start_q <= start_d;
            ind_q   <= ind_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath logic. CLEAR overrides everything, including ENTER.
    always_comb begin
        state_d = state_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        op_d    = op_q;
        start_d = 1'b0;
        ind_d   = ind_q;
        err_d   = 1'b0;
        cnt_d   = 8'h00;
        if (clear_ev) begin
            state_d = GET_A;
            reg1_d  = 4'h0;
            reg2_d  = 4'h0;
            op_d    = 2'd0;
            ind_d   = 8'h00;
        end else begin
            case (state_q)
                GET_A: begin
                    ind_d = {4'h0, in_number};
                    if (enter_ev) begin
                        reg1_d  = in_number;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    ind_d = {4'h0, in_number};
                    if (enter_ev) begin
                        reg2_d  = in_number;
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    ind_d = {6'h00, op_sel};
                    if (enter_ev) begin
                        op_d    = op_sel;
                        start_d = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // The count is held at 0 through the start-pulse cycle, so it
                    // reads 0 on the first cycle after alu_start.
                    cnt_d = start_q ? 8'h00 : cnt_q + 8'd1;
                    if (alu_done) begin
                        if (alu_err) begin
                            state_d = ERROR;
                            ind_d   = 8'hEE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = SHOW;
                            ind_d   = alu_result;
                        end
                    end else if (!start_q && (cnt_q == TIMEOUT_M1)) begin
                        state_d = ERROR;
                        ind_d   = 8'hEE;
                        err_d   = 1'b1;
                    end
                end
                SHOW: begin
                    if (enter_ev) begin
                        state_d = GET_A;
                    end
                end
                ERROR: begin
                    ind_d = 8'hEE;
                    err_d = 1'b1;
                end
                default: begin
                    state_d = GET_A;
                end
            endcase
        end
    end

    assign reg_1     = reg1_q;
    assign reg_2     = reg2_q;
    assign op        = op_q;
    assign alu_start = start_q;
    assign ind       = ind_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed vector table plus hand sequences for calc_seq.
module tb_calc_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_number = 4'h0;
    logic [1:0] key = 2'b00;
    logic [1:0] op_sel = 2'd0;
    logic       alu_done = 1'b0;
    logic       alu_err = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] reg_1;
    logic [3:0] reg_2;
    logic [1:0] op;
    logic       alu_start;
    logic [7:0] ind;
    logic       err;

    calc_seq #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_number  (in_number),
        .key        (key),
        .op_sel     (op_sel),
        .alu_done   (alu_done),
        .alu_err    (alu_err),
        .alu_result (alu_result),
        .reg_1      (reg_1),
        .reg_2      (reg_2),
        .op         (op),
        .alu_start  (alu_start),
        .ind        (ind),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] opc;
        int         dly;
        logic       aerr;
        logic [7:0] res;
        logic [7:0] exp_ind;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_start) start_cnt++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [1:0] k);
        key = k;
        repeat (4) tick();
        key = 2'b00;
        repeat (4) tick();
    endtask

    // Press ENTER in GET_OP and wait, within a bound, for the alu_start cycle.
    task automatic start_op(output bit ok);
        ok = 1'b0;
        key[0] = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (alu_start) ok = 1'b1;
        end
        key[0] = 1'b0;
    endtask

    // Called in the alu_start cycle; raise done dly cycles after the following cycle.
    task automatic alu_reply(input int dly, input logic e, input logic [7:0] r);
        tick();
        repeat (dly) tick();
        alu_done = 1'b1;
        alu_err = e;
        alu_result = r;
        tick();
        alu_done = 1'b0;
        alu_err = 1'b0;
        alu_result = 8'h00;
        tick();
    endtask

    task automatic enter_operands(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        in_number = 4'h0;
        press(2'b10);
        start_cnt = 0;
        in_number = a;
        press(2'b01);
        in_number = b;
        press(2'b01);
        op_sel = o;
    endtask

    initial begin
        bit ok;

        //           a      b      op    dly aerr res     ind     err
        vecs[0] = '{4'd3,  4'd5,  2'd0, 4,  1'b0, 8'h08, 8'h08, 1'b0};
        vecs[1] = '{4'd3,  4'd4,  2'd3, 2,  1'b1, 8'h00, 8'hEE, 1'b1};
        vecs[2] = '{4'd7,  4'd2,  2'd2, 0,  1'b0, 8'h0E, 8'h0E, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 2'd1, 14, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{4'd9,  4'd4,  2'd2, 15, 1'b0, 8'h24, 8'hEE, 1'b1};
        vecs[5] = '{4'd12, 4'd3,  2'd3, 1,  1'b0, 8'h04, 8'h04, 1'b0};

        // Reset values.
        repeat (3) tick();
        chk("rst_reg_1", reg_1, 0);
        chk("rst_reg_2", reg_2, 0);
        chk("rst_op", op, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_ind", ind, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Table-driven full operations.
        for (int v = 0; v < 6; v++) begin
            enter_operands(vecs[v].a, vecs[v].b, vecs[v].opc);
            start_op(ok);
            chk("vec_start_seen", ok, 1);
            alu_reply(vecs[v].dly, vecs[v].aerr, vecs[v].res);
            chk("vec_reg_1", reg_1, vecs[v].a);
            chk("vec_reg_2", reg_2, vecs[v].b);
            chk("vec_op", op, vecs[v].opc);
            chk("vec_ind", ind, vecs[v].exp_ind);
            chk("vec_err", err, vecs[v].exp_err);
            chk("vec_start_pulses", 8'(start_cnt), 1);
            $display("vec %0d: a=%0d b=%0d op=%0d dly=%0d ind=%h err=%0d", v, vecs[v].a, vecs[v].b,
                     vecs[v].opc, vecs[v].dly, ind, err);
        end

        // ALU error, ENTER ignored in ERROR, then CLEAR returns everything to zero.
        enter_operands(4'd3, 4'd5, 2'd3);
        start_op(ok);
        chk("err_start_seen", ok, 1);
        alu_reply(3, 1'b1, 8'h00);
        chk("err_ind", ind, 8'hEE);
        chk("err_err", err, 1);
        in_number = 4'h0;
        press(2'b01);
        chk("err_enter_ignored", err, 1);
        press(2'b10);
        chk("clr_reg_1", reg_1, 0);
        chk("clr_reg_2", reg_2, 0);
        chk("clr_op", op, 0);
        chk("clr_ind", ind, 0);
        chk("clr_err", err, 0);
        chk("clr_start", alu_start, 0);
        $display("seq error_clear: ind=%h err=%0d", ind, err);

        // Timeout: ERROR appears exactly 15 cycles after the cycle following alu_start.
        enter_operands(4'd5, 4'd5, 2'd1);
        start_op(ok);
        chk("to_start_seen", ok, 1);
        tick();
        for (int k = 0; k <= 15; k++) begin
            chk($sformatf("to_err_k%0d", k), err, 8'(k == 15));
            if (k < 15) tick();
        end
        chk("to_ind", ind, 8'hEE);
        $display("seq timeout: ind=%h err=%0d", ind, err);

        // SHOW then ENTER: back to GET_A with registers retained and ind tracking.
        enter_operands(4'd3, 4'd5, 2'd0);
        start_op(ok);
        alu_reply(4, 1'b0, 8'h08);
        chk("show_ind", ind, 8'h08);
        in_number = 4'd6;
        press(2'b01);
        chk("ret_reg_1", reg_1, 3);
        chk("ret_reg_2", reg_2, 5);
        chk("ret_ind_tracks", ind, 8'h06);
        $display("seq show_return: reg_1=%0d reg_2=%0d ind=%h", reg_1, reg_2, ind);

        // CLEAR together with ENTER in GET_B acts as CLEAR only.
        in_number = 4'h0;
        press(2'b10);
        in_number = 4'd4;
        press(2'b01);
        in_number = 4'd9;
        press(2'b11);
        chk("both_reg_1", reg_1, 0);
        chk("both_reg_2", reg_2, 0);
        in_number = 4'd2;
        press(2'b01);
        chk("both_in_get_a", reg_1, 2);
        chk("both_reg_2_after", reg_2, 0);
        $display("seq clear_enter: reg_1=%0d reg_2=%0d", reg_1, reg_2);

        // Key held through reset release must not fire until pressed again.
        rst_n = 1'b0;
        key[0] = 1'b1;
        in_number = 4'd7;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("held_no_event", reg_1, 0);
        key = 2'b00;
        repeat (4) tick();
        press(2'b01);
        chk("held_repress", reg_1, 7);
        $display("seq held_reset: reg_1=%0d", reg_1);

        // Reset pulsed during EXEC; a late alu_done is ignored.
        enter_operands(4'd1, 4'd2, 2'd0);
        start_op(ok);
        chk("rx_start_seen", ok, 1);
        in_number = 4'h0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rx_async_reg_1", reg_1, 0);
        chk("rx_async_reg_2", reg_2, 0);
        chk("rx_async_err", err, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        alu_done = 1'b1;
        alu_result = 8'h55;
        tick();
        alu_done = 1'b0;
        alu_result = 8'h00;
        repeat (3) tick();
        chk("rx_reg_1", reg_1, 0);
        chk("rx_op", op, 0);
        chk("rx_ind", ind, 0);
        chk("rx_err", err, 0);
        in_number = 4'd5;
        press(2'b01);
        chk("rx_get_a", reg_1, 5);
        $display("seq reset_exec: reg_1=%0d ind=%h err=%0d", reg_1, ind, err);

        // ENTER held 100 cycles gives one event; ENTER during EXEC is ignored.
        in_number = 4'h0;
        press(2'b10);
        in_number = 4'd4;
        key[0] = 1'b1;
        repeat (50) tick();
        in_number = 4'd8;
        repeat (50) tick();
        key = 2'b00;
        repeat (4) tick();
        chk("hold_reg_1", reg_1, 4);
        chk("hold_reg_2", reg_2, 0);
        in_number = 4'd6;
        press(2'b01);
        chk("hold_one_step", reg_2, 6);
        op_sel = 2'd2;
        start_cnt = 0;
        start_op(ok);
        chk("hold_start_seen", ok, 1);
        tick();
        op_sel = 2'd1;
        press(2'b01);
        repeat (2) tick();
        alu_done = 1'b1;
        alu_result = 8'h18;
        tick();
        alu_done = 1'b0;
        alu_result = 8'h00;
        tick();
        chk("exec_enter_ind", ind, 8'h18);
        chk("exec_enter_err", err, 0);
        chk("exec_enter_op", op, 2);
        chk("exec_enter_pulses", 8'(start_cnt), 1);
        $display("seq enter_hold_exec: ind=%h op=%0d pulses=%0d", ind, op, start_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
